dram_responder: RTL and testbench
=================================

// Module: dram_responder
// PURPOSE
// - Byte-lane DRAM responder (slave end) of the 8-lane dram_* request interface driven by memcpy and other initiators.
// - Holds a MEM_BYTES byte store, commits per-lane writes and returns per-lane read data after a fixed READ_LAT pipeline.
// - Used as the on-chip scratch DRAM and as the DRAM model in block benches.
// PARAMETERS
// - MEM_BYTES  default 4096  store size in bytes; must be a power of 2; AW = $clog2(MEM_BYTES).
// - READ_LAT   default 4     cycles from read request to dram_valid; legal range 1..16.
// PORTS
// - clk          in   1      clock; all logic on posedge.
// - reset        in   1      synchronous, active-high reset.
// - dram_en      in   8      per-lane request enable; a lane is requested in any cycle where its bit is 1.
// - dram_rdwr    in   1      1 = read, 0 = write; shared by all lanes in that cycle.
// - dram_addr    in   8x64   per-lane byte address.
// - dram_wdata   in   8x8    per-lane write byte; connects to the initiator's dram_data_out.
// - dram_rdata   out  8x8    per-lane read byte; connects to the initiator's dram_data_in.
// - dram_valid   out  8      per-lane read-data valid; one-cycle pulse.
// - rd_cnt       out  32     count of lane reads accepted, wrapping.
// - wr_cnt       out  32     count of lane writes committed, wrapping.
// - addr_err     out  1      sticky out-of-range flag; see CONFIGURATION.
// BEHAVIOUR
// - Reset values: dram_rdata=0, dram_valid=0, rd_cnt=0, wr_cnt=0, addr_err=0, read pipe flushed. Store contents are not reset.
// - Index: idx = dram_addr[i][AW-1:0]. Without the macro, upper address bits are ignored and addresses wrap modulo MEM_BYTES.
// - Write (en[i]=1, rdwr=0 in cycle t): mem[idx] <= wdata[i] at the end of cycle t. wr_cnt increments by popcount(en) at that edge.
// - Same-cycle write collision (two lanes, same idx): the higher lane number wins.
// - Read (en[i]=1, rdwr=1 in cycle t): mem[idx] is sampled in cycle t.
//   - The sample sees every write committed at or before the end of cycle t-1.
//   - The sampled byte and lane bit enter stage 0 of a READ_LAT-deep pipe. rd_cnt increments by popcount(en).
// - Response: in cycle t+READ_LAT, dram_valid[i]=1 and dram_rdata[i]=sampled byte, for exactly one cycle.
//   - Lanes not requested in cycle t have valid=0 and rdata=0 in that cycle.
// - Fully pipelined: a new request (read or write) is accepted every cycle. No backpressure and no busy output.
//   - Back-to-back reads give back-to-back valid pulses, in order.
// - dram_en=0: no access, the counters hold, and a bubble enters the pipe.
// - Reads in flight are unaffected by writes issued after them: data is captured at request time.
// - Reset mid-operation: in-flight reads are discarded, and dram_valid=0 from the cycle after the reset edge.
//   - A request in the reset cycle is ignored; no write commits.
// - READ_LAT=1: a read in cycle t responds in cycle t+1 from a registered output. There is no combinational path from request to rdata.
// - Counter width: each cycle adds 0..8; the count wraps at 2^32 without a flag.
// CONFIGURATION
// - Macro DRAM_RESP_BOUNDS_EN.
// - Defined: a lane with en=1 and dram_addr[i] >= MEM_BYTES is out of range.
//   - An out-of-range write is dropped and does not count toward wr_cnt.
//   - An out-of-range read returns rdata=0 with valid=1 at the normal latency, and still counts toward rd_cnt.
//   - addr_err is set at the end of that cycle and stays 1 until reset.
// - Not defined: the address wraps modulo MEM_BYTES, addr_err is tied to 0, and no checking logic is built.
// TESTING
// - Write lanes 0..7 at addr 0x100..0x107 with 0xA0..0xA7, then read the same addresses next cycle.
//   Required: valid=8'hFF exactly READ_LAT cycles later, rdata=A0..A7, wr_cnt=8, rd_cnt=8.
// - Partial read: en=8'h07 at addr 0x100.. -> valid=8'h07, rdata lanes 0..2 = A0..A2, lanes 3..7 = 0.
// - Write 0x55 to 0x200, read 0x200, then write 0xAA to 0x200 on the next cycle -> read returns 0x55; a later read returns 0xAA.
// - Lanes 2 and 5 write 0x11/0x22 to the same addr 0x300 -> a subsequent read returns 0x22.
// - Reads on 3 consecutive cycles, with reset asserted the cycle after the last request -> no valid pulse ever appears.
//   Required: counters=0 and store data intact.
// - With DRAM_RESP_BOUNDS_EN: read addr MEM_BYTES+4 -> valid=1, rdata=0, addr_err=1 and sticky.
//   Without the macro: the same read returns mem[4] and addr_err stays 0.

Source files
------------

// File: rtl/dram_responder.sv
// Byte-lane DRAM responder: 8-lane write/read slave over a MEM_BYTES store with a READ_LAT-deep read pipe.
// Optional address bounds checking is built when DRAM_RESP_BOUNDS_EN is defined.
module dram_responder #(
    parameter int unsigned MEM_BYTES = 4096,
    parameter int unsigned READ_LAT  = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [7:0]       dram_en,
    input  logic             dram_rdwr,
    input  logic [7:0][63:0] dram_addr,
    input  logic [7:0][7:0]  dram_wdata,
    output logic [7:0][7:0]  dram_rdata,
    output logic [7:0]       dram_valid,
    output logic [31:0]      rd_cnt,
    output logic [31:0]      wr_cnt,
    output logic             addr_err
);

    localparam int unsigned AW = $clog2(MEM_BYTES);

    logic [7:0]          mem [MEM_BYTES];
    logic [AW-1:0]       idx [8];
    logic [7:0]          oor;
    logic [7:0]          rd_lane;
    logic [7:0]          wr_lane;
    logic [7:0][7:0]     rd_byte;
    logic [7:0]          pipe_valid [READ_LAT];
    logic [63:0]         pipe_data  [READ_LAT];

    function automatic logic [3:0] popcount8(input logic [7:0] v);
        logic [3:0] n;
        n = '0;
        for (int unsigned i = 0; i < 8; i++) begin
            n = n + 4'(v[i]);
        end
        return n;
    endfunction

    always_comb begin
        for (int unsigned i = 0; i < 8; i++) begin
            idx[i] = dram_addr[i][AW-1:0];
        end
    end

`ifdef DRAM_RESP_BOUNDS_EN
    always_comb begin
        oor = '0;
        for (int unsigned i = 0; i < 8; i++) begin
            oor[i] = (dram_addr[i] >= 64'(MEM_BYTES));
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            addr_err <= 1'b0;
        end else if (|(dram_en & oor)) begin
            addr_err <= 1'b1;
        end
    end
`else
    logic addr_hi_unused;

    always_comb begin
        addr_hi_unused = 1'b0;
        for (int unsigned i = 0; i < 8; i++) begin
            addr_hi_unused = addr_hi_unused ^ (^dram_addr[i][63:AW]);
        end
    end

    assign oor      = '0;
    assign addr_err = 1'b0;
`endif

    assign rd_lane = dram_en & {8{dram_rdwr}};
    assign wr_lane = dram_en & ~{8{dram_rdwr}} & ~oor;

    // Read sample uses the pre-edge store, so it never sees a same-cycle write.
    always_comb begin
        rd_byte = '0;
        for (int unsigned i = 0; i < 8; i++) begin
            if (rd_lane[i] && !oor[i]) begin
                rd_byte[i] = mem[idx[i]];
            end
        end
    end

    // Ascending lane order: the highest colliding lane's assignment lands last.
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int unsigned i = 0; i < 8; i++) begin
                if (wr_lane[i]) begin
                    mem[idx[i]] <= dram_wdata[i];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned k = 0; k < READ_LAT; k++) begin
                pipe_valid[k] <= '0;
                pipe_data[k]  <= '0;
            end
        end else begin
            pipe_valid[0] <= rd_lane;
            pipe_data[0]  <= rd_byte;
            for (int unsigned k = 1; k < READ_LAT; k++) begin
                pipe_valid[k] <= pipe_valid[k-1];
                pipe_data[k]  <= pipe_data[k-1];
            end
        end
    end

    assign dram_valid = pipe_valid[READ_LAT-1];
    assign dram_rdata = pipe_data[READ_LAT-1];

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_cnt <= '0;
            wr_cnt <= '0;
        end else begin
            rd_cnt <= rd_cnt + 32'(popcount8(rd_lane));
            wr_cnt <= wr_cnt + 32'(popcount8(wr_lane));
        end
    end

endmodule

// File: tb/tb_dram_responder.sv
// Scoreboard bench for dram_responder: stimulus pushes expected read responses, a negedge monitor checks them.
module tb_dram_responder;

    localparam int unsigned MEM_BYTES = 4096;
    localparam int unsigned LAT       = 4;

    logic             clk = 1'b0;
    logic             reset;
    logic [7:0]       dram_en;
    logic             dram_rdwr;
    logic [7:0][63:0] dram_addr;
    logic [7:0][7:0]  dram_wdata;
    logic [7:0][7:0]  dram_rdata;
    logic [7:0]       dram_valid;
    logic [31:0]      rd_cnt;
    logic [31:0]      wr_cnt;
    logic             addr_err;

    dram_responder #(.MEM_BYTES(MEM_BYTES), .READ_LAT(LAT)) dut (
        .clk        (clk),
        .reset      (reset),
        .dram_en    (dram_en),
        .dram_rdwr  (dram_rdwr),
        .dram_addr  (dram_addr),
        .dram_wdata (dram_wdata),
        .dram_rdata (dram_rdata),
        .dram_valid (dram_valid),
        .rd_cnt     (rd_cnt),
        .wr_cnt     (wr_cnt),
        .addr_err   (addr_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          cyc;
        logic [7:0]  valid;
        logic [63:0] data;
    } exp_t;

    exp_t        sb[$];
    exp_t        e;
    int          checks = 0;
    int          errors = 0;
    bit          mon_on = 1'b0;
    int unsigned exp_rd = 0;
    int unsigned exp_wr = 0;

    always @(negedge clk) begin
        if (mon_on) begin
            if (sb.size() > 0 && sb[0].cyc < cyc) begin
                e = sb.pop_front();
                checks++;
                errors++;
                $display("FAIL missed_resp due_cycle=%0d now=%0d", e.cyc, cyc);
            end else if (sb.size() > 0 && sb[0].cyc == cyc) begin
                e = sb.pop_front();
                checks++;
                if (dram_valid !== e.valid || dram_rdata !== e.data) begin
                    errors++;
                    $display("FAIL resp cycle=%0d valid=%h rdata=%h expected valid=%h rdata=%h",
                             cyc, dram_valid, dram_rdata, e.valid, e.data);
                end
            end else if (dram_valid !== 8'h00 || dram_rdata !== 64'h0) begin
                checks++;
                errors++;
                $display("FAIL spurious_resp cycle=%0d valid=%h rdata=%h expected valid=00 rdata=0",
                         cyc, dram_valid, dram_rdata);
            end
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%h expected=%h", name, act, exp);
        end
    endtask

    // One request cycle; lane i addresses base + i*stride.
    task automatic issue(input logic [7:0] en, input logic rd, input logic [63:0] base,
                         input int stride, input logic [63:0] wd, input bit track,
                         input logic [7:0] ev, input logic [63:0] ed);
        @(posedge clk);
        #1;
        dram_en   = en;
        dram_rdwr = rd;
        for (int i = 0; i < 8; i++) begin
            dram_addr[i] = base + 64'(i * stride);
        end
        dram_wdata = wd;
        if (track) begin
            sb.push_back('{cyc + int'(LAT), ev, ed});
        end
        if (rd) exp_rd += $countones(en);
        else    exp_wr += $countones(en);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            dram_en = '0;
        end
    endtask

    initial begin
        reset      = 1'b1;
        dram_en    = '0;
        dram_rdwr  = 1'b0;
        dram_addr  = '0;
        dram_wdata = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_valid", 64'(dram_valid), 64'h0);
        check("reset_rdata", dram_rdata, 64'h0);
        check("reset_rd_cnt", 64'(rd_cnt), 64'h0);
        check("reset_wr_cnt", 64'(wr_cnt), 64'h0);
        check("reset_addr_err", 64'(addr_err), 64'h0);
        @(posedge clk);
        #1;
        reset  = 1'b0;
        mon_on = 1'b1;

        // Full-width write then immediate read-back
        issue(8'hFF, 1'b0, 64'h100, 1, 64'hA7A6A5A4A3A2A1A0, 1'b0, 8'h00, 64'h0);
        issue(8'hFF, 1'b1, 64'h100, 1, 64'h0, 1'b1, 8'hFF, 64'hA7A6A5A4A3A2A1A0);
        idle(LAT + 2);
        check("wr_cnt_full", 64'(wr_cnt), 64'd8);
        check("rd_cnt_full", 64'(rd_cnt), 64'd8);

        // Partial lanes
        issue(8'h07, 1'b1, 64'h100, 1, 64'h0, 1'b1, 8'h07, 64'h0000000000A2A1A0);
        idle(2);

        // Read data is captured at request time
        issue(8'h01, 1'b0, 64'h200, 0, 64'h55, 1'b0, 8'h00, 64'h0);
        issue(8'h01, 1'b1, 64'h200, 0, 64'h0, 1'b1, 8'h01, 64'h55);
        issue(8'h01, 1'b0, 64'h200, 0, 64'hAA, 1'b0, 8'h00, 64'h0);
        issue(8'h01, 1'b1, 64'h200, 0, 64'h0, 1'b1, 8'h01, 64'hAA);
        issue(8'h80, 1'b1, 64'h200, 0, 64'h0, 1'b1, 8'h80, 64'hAA00000000000000);
        idle(2);

        // Lanes 2 and 5 collide on 0x300; lane 5 must win
        issue(8'h24, 1'b0, 64'h300, 0, 64'h0000220000110000, 1'b0, 8'h00, 64'h0);
        issue(8'h01, 1'b1, 64'h300, 0, 64'h0, 1'b1, 8'h01, 64'h22);
        idle(LAT + 2);
        check("wr_cnt_mid", 64'(wr_cnt), 64'(exp_wr));
        check("rd_cnt_mid", 64'(rd_cnt), 64'(exp_rd));

        // Address MEM_BYTES+4
        issue(8'h02, 1'b0, 64'h3, 1, 64'h5A00, 1'b0, 8'h00, 64'h0);
`ifdef DRAM_RESP_BOUNDS_EN
        issue(8'h01, 1'b1, 64'(MEM_BYTES + 4), 0, 64'h0, 1'b1, 8'h01, 64'h0);
        idle(LAT + 2);
        check("addr_err_set", 64'(addr_err), 64'h1);
        idle(3);
        check("addr_err_sticky", 64'(addr_err), 64'h1);
`else
        issue(8'h01, 1'b1, 64'(MEM_BYTES + 4), 0, 64'h0, 1'b1, 8'h01, 64'h5A);
        idle(LAT + 2);
        check("addr_err_clear", 64'(addr_err), 64'h0);
        idle(3);
        check("addr_err_still_clear", 64'(addr_err), 64'h0);
`endif
        check("rd_cnt_oor", 64'(rd_cnt), 64'(exp_rd));

        // Reads in flight are discarded by reset; the reset-cycle write is ignored
        issue(8'hFF, 1'b1, 64'h100, 1, 64'h0, 1'b0, 8'h00, 64'h0);
        issue(8'hFF, 1'b1, 64'h100, 1, 64'h0, 1'b0, 8'h00, 64'h0);
        issue(8'hFF, 1'b1, 64'h100, 1, 64'h0, 1'b0, 8'h00, 64'h0);
        issue(8'h01, 1'b0, 64'h100, 0, 64'hEE, 1'b0, 8'h00, 64'h0);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset   = 1'b0;
        dram_en = '0;
        exp_rd  = 0;
        exp_wr  = 0;
        idle(LAT + 4);
        check("post_reset_rd_cnt", 64'(rd_cnt), 64'h0);
        check("post_reset_wr_cnt", 64'(wr_cnt), 64'h0);
        check("post_reset_addr_err", 64'(addr_err), 64'h0);

        issue(8'hFF, 1'b1, 64'h100, 1, 64'h0, 1'b1, 8'hFF, 64'hA7A6A5A4A3A2A1A0);
        issue(8'h10, 1'b1, 64'h300, 0, 64'h0, 1'b1, 8'h10, 64'h0000002200000000);
        idle(LAT + 3);
        check("final_rd_cnt", 64'(rd_cnt), 64'(exp_rd));
        check("final_wr_cnt", 64'(wr_cnt), 64'(exp_wr));

        mon_on = 1'b0;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            checks++;
            errors++;
            $display("FAIL pending_resp due_cycle=%0d never_seen", e.cyc);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
